// File: rtl/mac_rx.sv
// mac_rx: locks onto preamble/SFD, filters on destination MAC and ethertype, and emits one
// 32-bit payload word per accepted frame. Define MAC_RX_CRC_CHECK_EN to verify the FCS.
module mac_rx #(
    parameter logic [47:0] LOCAL_MAC = 48'h000A35C60000,
    parameter logic [15:0] ETH_TYPE  = 16'h6969,
    parameter int unsigned PRE_MIN   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] data_out,
    output logic        dval_out,
    output logic [47:0] src_mac_out,
    output logic        frame_drop,
    output logic [15:0] drop_cnt
);

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [5:0]  PRE_MIN_C = 6'(PRE_MIN);
    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;

    typedef enum logic [2:0] {
        HUNT,
        DEST,
        SRC,
        TYPE,
        PAYLOAD,
        FCS
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    // Only the first five destination bytes are stored; the sixth is compared as it arrives.
    logic [39:0] dest_sr_q, dest_sr_d;
    logic [47:0] src_sr_q, src_sr_d;
    logic [7:0]  type_hi_q, type_hi_d;
    logic [31:0] pay_sr_q, pay_sr_d;

    logic [31:0] data_q, data_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic        dval_q, dval_d;
    logic        drop_q, drop_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        accept;
    logic        drop;

`ifdef MAC_RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d;
    logic [23:0] fcs_sr_q, fcs_sr_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pre_cnt_d = pre_cnt_q;
        dest_sr_d = dest_sr_q;
        src_sr_d  = src_sr_q;
        type_hi_d = type_hi_q;
        pay_sr_d  = pay_sr_q;
        accept    = 1'b0;
        drop      = 1'b0;
`ifdef MAC_RX_CRC_CHECK_EN
        crc_d     = crc_q;
        fcs_sr_d  = fcs_sr_q;
`endif

        if (byte_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (byte_in == PRE_BYTE) begin
                        if (pre_cnt_q != 6'h3F) begin
                            pre_cnt_d = pre_cnt_q + 6'd1;
                        end
                    end else if (byte_in == SFD_BYTE && pre_cnt_q >= PRE_MIN_C) begin
                        state_d   = DEST;
                        pre_cnt_d = 6'd0;
                        idx_d     = 3'd0;
`ifdef MAC_RX_CRC_CHECK_EN
                        crc_d     = 32'hFFFF_FFFF;
`endif
                    end else begin
                        pre_cnt_d = 6'd0;
                    end
                end

                DEST: begin
                    dest_sr_d = {dest_sr_q[31:0], byte_in};
`ifdef MAC_RX_CRC_CHECK_EN
                    crc_d     = crc32_byte(crc_q, byte_in);
`endif
                    if (idx_q == 3'd5) begin
                        idx_d = 3'd0;
                        if ({dest_sr_q, byte_in} == LOCAL_MAC || {dest_sr_q, byte_in} == BCAST_MAC) begin
                            state_d = SRC;
                        end else begin
                            drop    = 1'b1;
                            state_d = HUNT;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end

                SRC: begin
                    src_sr_d = {src_sr_q[39:0], byte_in};
`ifdef MAC_RX_CRC_CHECK_EN
                    crc_d    = crc32_byte(crc_q, byte_in);
`endif
                    if (idx_q == 3'd5) begin
                        idx_d   = 3'd0;
                        state_d = TYPE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end

                TYPE: begin
`ifdef MAC_RX_CRC_CHECK_EN
                    crc_d = crc32_byte(crc_q, byte_in);
`endif
                    if (idx_q == 3'd0) begin
                        type_hi_d = byte_in;
                        idx_d     = 3'd1;
                    end else begin
                        idx_d = 3'd0;
                        if ({type_hi_q, byte_in} == ETH_TYPE) begin
                            state_d = PAYLOAD;
                        end else begin
                            drop    = 1'b1;
                            state_d = HUNT;
                        end
                    end
                end

                PAYLOAD: begin
                    pay_sr_d = {pay_sr_q[23:0], byte_in};
`ifdef MAC_RX_CRC_CHECK_EN
                    crc_d    = crc32_byte(crc_q, byte_in);
`endif
                    if (idx_q == 3'd3) begin
                        idx_d   = 3'd0;
                        state_d = FCS;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end

                FCS: begin
`ifdef MAC_RX_CRC_CHECK_EN
                    fcs_sr_d = {byte_in, fcs_sr_q[23:8]};
`endif
                    if (idx_q == 3'd3) begin
                        idx_d   = 3'd0;
                        state_d = HUNT;
`ifdef MAC_RX_CRC_CHECK_EN
                        // FCS arrives LSB byte first, so the newest byte is the top byte.
                        if ({byte_in, fcs_sr_q} == ~crc_q) begin
                            accept = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
`else
                        accept = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end

                default: begin
                    state_d = HUNT;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        data_d     = data_q;
        src_mac_d  = src_mac_q;
        dval_d     = accept;
        drop_d     = drop;
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            data_d    = pay_sr_q;
            src_mac_d = src_sr_q;
        end
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            idx_q      <= 3'd0;
            pre_cnt_q  <= 6'd0;
            dest_sr_q  <= 40'd0;
            src_sr_q   <= 48'd0;
            type_hi_q  <= 8'd0;
            pay_sr_q   <= 32'd0;
            data_q     <= 32'd0;
            src_mac_q  <= 48'd0;
            dval_q     <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 16'd0;
`ifdef MAC_RX_CRC_CHECK_EN
            crc_q      <= 32'd0;
            fcs_sr_q   <= 24'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pre_cnt_q  <= pre_cnt_d;
            dest_sr_q  <= dest_sr_d;
            src_sr_q   <= src_sr_d;
            type_hi_q  <= type_hi_d;
            pay_sr_q   <= pay_sr_d;
            data_q     <= data_d;
            src_mac_q  <= src_mac_d;
            dval_q     <= dval_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef MAC_RX_CRC_CHECK_EN
            crc_q      <= crc_d;
            fcs_sr_q   <= fcs_sr_d;
`endif
        end
    end

    assign data_out    = data_q;
    assign dval_out    = dval_q;
    assign src_mac_out = src_mac_q;
    assign frame_drop  = drop_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_mac_rx.sv
// tb_mac_rx: scoreboard bench for mac_rx; expected accept/drop outcomes are queued when the
// deciding byte is driven and matched against dval_out/frame_drop pulses.
module tb_mac_rx;

    localparam logic [47:0] LOCAL_MAC = 48'h000A35C60000;
    localparam logic [47:0] BCAST_MAC = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] SRC_A     = 48'h000A35C70000;
    localparam logic [47:0] SRC_B     = 48'h000A35C71234;
    localparam logic [15:0] ETH_TYPE  = 16'h6969;
    localparam int          PRE_MIN   = 7;
`ifdef MAC_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [31:0] data_out;
    logic        dval_out;
    logic [47:0] src_mac_out;
    logic        frame_drop;
    logic [15:0] drop_cnt;

    mac_rx dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .data_out    (data_out),
        .dval_out    (dval_out),
        .src_mac_out (src_mac_out),
        .frame_drop  (frame_drop),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_drop;
        logic [31:0] data;
        logic [47:0] src;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          nCompared = 0;
    int          nMismatched = 0;
    logic [31:0] modelData = 32'd0;
    logic [47:0] modelSrc = 48'd0;
    logic [15:0] modelDrops = 16'd0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference CRC-32, reflected, processed one bit at a time.
    function automatic logic [31:0] refCrc(input logic [7:0] hdr[18]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 18; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ hdr[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    // Every output pulse must match the head of the scoreboard at the predicted cycle.
    always @(negedge clk) begin
        if (dval_out || frame_drop) begin
            checkOutput("pulse_exclusive", {63'd0, dval_out & frame_drop}, 64'd0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("pulse_cycle", cyc, e.due);
                checkOutput("pulse_kind", {63'd0, frame_drop}, {63'd0, e.is_drop});
                if (e.is_drop) begin
                    if (modelDrops != 16'hFFFF) modelDrops = modelDrops + 16'd1;
                end else begin
                    modelData = e.data;
                    modelSrc  = e.src;
                end
                checkOutput("data_out", data_out, modelData);
                checkOutput("src_mac_out", src_mac_out, modelSrc);
                checkOutput("drop_cnt", drop_cnt, modelDrops);
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input int gap);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // Builds one frame, predicts its outcome, and drives it; trunc<0 sends the whole frame.
    // crcPay is the payload the FCS is computed over; useDeadBeef sends DE AD BE EF as FCS.
    task automatic applyStimulus(input int npre, input logic [47:0] dest, input logic [47:0] src,
                                 input logic [15:0] etype, input logic [31:0] pay,
                                 input logic [31:0] crcPay, input bit useDeadBeef,
                                 input int gap, input int trunc);
        logic [7:0]  fr[$];
        logic [7:0]  hdr[18];
        logic [7:0]  fcsB[4];
        logic [31:0] crc;
        logic [31:0] rxFcs;
        int          decide;
        int          sfdPos;
        exp_t        e;

        for (int i = 0; i < 6; i++) hdr[i]      = dest[(5 - i) * 8 +: 8];
        for (int i = 0; i < 6; i++) hdr[6 + i]  = src[(5 - i) * 8 +: 8];
        for (int i = 0; i < 2; i++) hdr[12 + i] = etype[(1 - i) * 8 +: 8];
        for (int i = 0; i < 4; i++) hdr[14 + i] = crcPay[(3 - i) * 8 +: 8];
        crc = refCrc(hdr);
        for (int i = 0; i < 4; i++) hdr[14 + i] = pay[(3 - i) * 8 +: 8];

        if (useDeadBeef) begin
            fcsB[0] = 8'hDE; fcsB[1] = 8'hAD; fcsB[2] = 8'hBE; fcsB[3] = 8'hEF;
        end else begin
            for (int i = 0; i < 4; i++) fcsB[i] = crc[i * 8 +: 8];
        end
        rxFcs = {fcsB[3], fcsB[2], fcsB[1], fcsB[0]};

        for (int i = 0; i < npre; i++) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        sfdPos = npre;
        for (int i = 0; i < 18; i++) fr.push_back(hdr[i]);
        for (int i = 0; i < 4; i++) fr.push_back(fcsB[i]);

        e.data    = pay;
        e.src     = src;
        e.is_drop = 1'b0;
        e.due     = 0;
        if (npre < PRE_MIN) begin
            decide = -1;
        end else if (dest != LOCAL_MAC && dest != BCAST_MAC) begin
            decide    = sfdPos + 6;
            e.is_drop = 1'b1;
        end else if (etype != ETH_TYPE) begin
            decide    = sfdPos + 14;
            e.is_drop = 1'b1;
        end else begin
            decide    = sfdPos + 22;
            e.is_drop = CRC_EN && (rxFcs != crc);
        end
        if (trunc >= 0 && decide >= trunc) decide = -1;

        for (int i = 0; i < fr.size(); i++) begin
            if (trunc >= 0 && i >= trunc) break;
            if (i == decide) begin
                e.due = cyc + 1;
                exp_q.push_back(e);
            end
            sendByte(fr[i], gap);
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        checkOutput("pending_results", exp_q.size(), 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data_out"}, data_out, 32'd0);
        checkOutput({tag, "_dval_out"}, {63'd0, dval_out}, 64'd0);
        checkOutput({tag, "_src_mac_out"}, src_mac_out, 48'd0);
        checkOutput({tag, "_frame_drop"}, {63'd0, frame_drop}, 64'd0);
        checkOutput({tag, "_drop_cnt"}, drop_cnt, 16'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkAllZero("reset");

        $display("[TB] good frame after reset");
        applyStimulus(7, LOCAL_MAC, SRC_A, ETH_TYPE, 32'h12345678, 32'h12345678, 1'b0, 0, -1);
        settle();
        checkOutput("good_data", data_out, 32'h12345678);
        checkOutput("good_src", src_mac_out, 48'h000A35C70000);
        checkOutput("good_drops", drop_cnt, 16'd0);

        $display("[TB] wrong dest then back-to-back good frame");
        applyStimulus(7, 48'h000A35C60001, SRC_A, ETH_TYPE, 32'h11111111, 32'h11111111, 1'b0, 0, -1);
        applyStimulus(8, LOCAL_MAC, SRC_B, ETH_TYPE, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0, -1);
        settle();
        checkOutput("dest_drops", drop_cnt, 16'd1);
        checkOutput("b2b_data", data_out, 32'hDEADBEEF);
        checkOutput("b2b_src", src_mac_out, SRC_B);

        $display("[TB] wrong type then broadcast");
        applyStimulus(7, LOCAL_MAC, SRC_A, 16'h0800, 32'h22222222, 32'h22222222, 1'b0, 0, -1);
        applyStimulus(9, BCAST_MAC, SRC_A, ETH_TYPE, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 0, -1);
        settle();
        checkOutput("type_drops", drop_cnt, 16'd2);
        checkOutput("bcast_data", data_out, 32'hCAFEF00D);

        $display("[TB] short preamble, then gapped good frame");
        applyStimulus(5, LOCAL_MAC, SRC_B, ETH_TYPE, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 0, -1);
        settle();
        checkOutput("short_pre_data", data_out, 32'hCAFEF00D);
        checkOutput("short_pre_drops", drop_cnt, 16'd2);
        applyStimulus(7, LOCAL_MAC, SRC_A, ETH_TYPE, 32'h12345678, 32'h12345678, 1'b0, 3, -1);
        settle();
        checkOutput("gap_data", data_out, 32'h12345678);
        checkOutput("gap_src", src_mac_out, 48'h000A35C70000);

        $display("[TB] corrupted payload bit");
`ifdef MAC_RX_CRC_CHECK_EN
        applyStimulus(7, LOCAL_MAC, SRC_B, ETH_TYPE, 32'h12345679, 32'h12345678, 1'b0, 0, -1);
        settle();
        checkOutput("crc_bad_data", data_out, 32'h12345678);
        checkOutput("crc_bad_drops", drop_cnt, 16'd3);
`else
        applyStimulus(7, LOCAL_MAC, SRC_B, ETH_TYPE, 32'h12345679, 32'h12345678, 1'b1, 0, -1);
        settle();
        checkOutput("nocrc_data", data_out, 32'h12345679);
        checkOutput("nocrc_drops", drop_cnt, 16'd2);
`endif

        $display("[TB] reset during payload");
        applyStimulus(7, LOCAL_MAC, SRC_A, ETH_TYPE, 32'h55D555D5, 32'h55D555D5, 1'b0, 0, 7 + 1 + 14 + 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkAllZero("midreset");
        modelData  = 32'd0;
        modelSrc   = 48'd0;
        modelDrops = 16'd0;
        applyStimulus(7, LOCAL_MAC, SRC_B, ETH_TYPE, 32'hA5A55A5A, 32'hA5A55A5A, 1'b0, 1, -1);
        settle();
        checkOutput("post_reset_data", data_out, 32'hA5A55A5A);
        checkOutput("post_reset_drops", drop_cnt, 16'd0);

        $display("[TB] drop counter saturation");
        @(negedge clk);
        force dut.drop_cnt_q = 16'hFFFD;
        @(posedge clk);
        @(negedge clk);
        release dut.drop_cnt_q;
        modelDrops = 16'hFFFD;
        @(negedge clk);
        checkOutput("preload_drops", drop_cnt, 16'hFFFD);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(7, 48'h123456789ABC, SRC_A, ETH_TYPE, 32'h33333333, 32'h33333333, 1'b0, 0, -1);
        end
        settle();
        checkOutput("sat_drops", drop_cnt, 16'hFFFF);
        checkOutput("sat_data", data_out, 32'hA5A55A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
